dadd_datapath: RTL and testbench
================================

Name: dadd_datapath

Overview:
- Blitter data-adder datapath; consumes the add-control strobes from the data-control logic.
- Holds the Gouraud pattern registers (patd, patf), the Z registers (srcz1 = fraction, srcz2 = integer) and their increments.
- Each strobe performs a four-lane (4 × 16-bit) add with fraction-to-integer carry chaining.
- Drives the registered adder result daddq onto the blitter data path.

Parameters:
- LANES, 4, number of 16-bit pixel lanes (fixed at 4; daddq is 64 bits).
- SAT_EN, 1, 1 = intensity mode saturates the low byte; 0 = intensity mode wraps.

Ports:
- sys_clk  in  1  system clock; all state updates on the rising edge.
- resetl  in  1  asynchronous active-low reset.
- gpu_din  in  32  GPU write data for register loads.
- reg_ld  in  3  register load select: 0 none, 1 patd, 2 patf, 3 srcz1, 4 srcz2, 5 iinc, 6 zinc, 7 none.
- reg_hi  in  1  for 64-bit registers: 1 = load bits 63:32, 0 = load bits 31:0.
- daddasel  in  3  A-operand select.
- daddbsel  in  3  B-operand select.
- daddmode  in  3  adder mode.
- daddq_sel  in  1  data path takes daddq this cycle.
- patdadd, patfadd, srcz1add, srcz2add  in  1 each  add strobes.
- srcshadd  in  1  shade-add strobe (result only, no register update).
- srcd  in  64  source data for shading.
- shade  in  8  signed shade value.
- daddq  out  64  registered adder result.
- daddq_valid  out  1  daddq updated on the previous edge.
- protocol_err  out  1  sticky: more than one add strobe was seen in the same cycle.

Behaviour:
- Reset: every register and output is 0 (patd, patf, srcz1, srcz2, iinc, zinc, icarry[3:0], zcarry[3:0], daddq, daddq_valid, protocol_err).
- Loads:
  - 64-bit registers take gpu_din into the half chosen by reg_hi.
  - iinc takes gpu_din[23:0]: integer in [23:16] (signed), fraction in [15:0].
  - zinc takes gpu_din[31:0]: integer in [31:16], fraction in [15:0].
- A-operand select (per lane): 000 srcd; 100 patd; 101 patf; 110 srcz2; 111 srcz1; any other code gives 0.
- B-operand select (per lane): 000 zero; 001 shade sign-extended to 16 bits; 100 iinc integer sign-extended; 101 iinc fraction; 110 zinc integer; 111 zinc fraction; 010/011 give zero.
- Adder modes (per lane, carry-in cin):
  - 000: A+B+cin, 16-bit wrap.
  - 001: A+B with cin = 0; the lane carry-out is captured.
  - 010: intensity. Result[15:8] = A[15:8]. Result[7:0] = A[7:0] + B[7:0] + cin, saturated to 00..FF when SAT_EN, with B treated as signed.
  - 1xx: result = A.
- Carry-in source:
  - icarry feeds patdadd; zcarry feeds srcz2add.
  - All other strobes use cin = 0.
  - The consuming strobe clears its carry register on the same edge.
- Per strobe, on the clock edge:
  - patfadd: patf ← result; icarry ← lane carries if mode 001.
  - patdadd: patd ← result; icarry ← 0.
  - srcz1add: srcz1 ← result; zcarry ← lane carries if mode 001.
  - srcz2add: srcz2 ← result; zcarry ← 0.
  - srcshadd: no register update.
- Output path:
  - daddq ← result when any strobe is active or daddq_sel = 1; otherwise daddq holds.
  - daddq_valid ← 1 in the cycle after any strobe, else 0.
  - Latency from strobe to daddq is 1 cycle.
- Simultaneous events:
  - A load to a register in the same cycle as a strobe targeting that register: the load wins and carries still update.
  - More than one add strobe in a cycle: priority patfadd > patdadd > srcz1add > srcz2add > srcshadd; only the winner executes and protocol_err sets.
  - protocol_err clears only on reset.
- Reset mid-sequence: pending carries are lost; a patdadd after reset uses cin = 0.

Test Plan:
- Reset; load patd = 0x0010_0020_0030_0040, iinc = 0x01_8000 → patfadd(mode 001, B = 101) on patf = 0x8000 per lane gives patf 0x0000 and icarry = 4'hF. Then patdadd(mode 000, B = 100) gives patd 0x0012_0022_0032_0042, daddq equal to it with daddq_valid = 1 one cycle later, and icarry = 0.
- Intensity saturation: patd lane = 0x12F0, iinc int = 0x20, mode 010 → lane 0x12FF. With iinc int = 0xE0 (−32) on lane 0x1210 → 0x1200.
- Z chain: srcz1 = 0xFFFF×4, zinc = 0x0003_0001; srcz1add mode 001 B = 111 → srcz1 = 0, zcarry = F. Then srcz2add on srcz2 = 0x0100 → 0x0104 per lane.
- Shade: srcd = 0x00FF_0080_0010_0000, shade = 0x10, mode 010, srcshadd → daddq = 0x00FF_0090_0020_0010 and no register changes.
- Strobe conflict: patdadd and srcz1add together → only patd updates; protocol_err = 1 and stays 1 until resetl is pulsed.
- Load/strobe collision: reg_ld = patd low half with gpu_din = 0xAAAA_5555 while patdadd is active → patd[31:0] = 0xAAAA_5555 and daddq = the adder result.

Source files
------------

// File: rtl/dadd_datapath_if.sv
// Bus bundle between the data-control logic and the blitter data-adder.
//
// Handshake: there is no backpressure. Each add strobe (patdadd, patfadd,
// srcz1add, srcz2add, srcshadd) is a single-cycle request that is always
// accepted on the rising edge it is sampled. The adder answers exactly one
// cycle later with daddq_valid high for one cycle and daddq carrying the
// result. daddq_sel is a plain capture request with no valid response.
interface dadd_datapath_if;
    logic [31:0] gpu_din;
    logic [2:0]  reg_ld;
    logic        reg_hi;
    logic [2:0]  daddasel;
    logic [2:0]  daddbsel;
    logic [2:0]  daddmode;
    logic        daddq_sel;
    logic        patdadd;
    logic        patfadd;
    logic        srcz1add;
    logic        srcz2add;
    logic        srcshadd;
    logic [63:0] srcd;
    logic [7:0]  shade;
    logic [63:0] daddq;
    logic        daddq_valid;
    logic        protocol_err;

    // Data-control side: issues loads, selects and strobes.
    modport master (
        output gpu_din, reg_ld, reg_hi, daddasel, daddbsel, daddmode,
        output daddq_sel, patdadd, patfadd, srcz1add, srcz2add, srcshadd,
        output srcd, shade,
        input  daddq, daddq_valid, protocol_err
    );

    // Adder side.
    modport slave (
        input  gpu_din, reg_ld, reg_hi, daddasel, daddbsel, daddmode,
        input  daddq_sel, patdadd, patfadd, srcz1add, srcz2add, srcshadd,
        input  srcd, shade,
        output daddq, daddq_valid, protocol_err
    );
endinterface

// File: rtl/dadd_datapath.sv
// Blitter data-adder datapath: Gouraud pattern registers (patd, patf),
// Z registers (srcz1 fraction, srcz2 integer), their increments, and a
// four-lane 16-bit adder whose fraction carries feed the integer adds.
module dadd_datapath #(
    parameter int LANES  = 4,     // 16-bit lanes; daddq is 64 bits so this stays 4
    parameter bit SAT_EN = 1'b1   // intensity mode: 1 saturates low byte, 0 wraps
) (
    input logic           sys_clk,
    input logic           resetl,
    dadd_datapath_if.slave bus
);

    localparam int DW = 16 * LANES;

    localparam logic [2:0] LD_PATD  = 3'd1;
    localparam logic [2:0] LD_PATF  = 3'd2;
    localparam logic [2:0] LD_SRCZ1 = 3'd3;
    localparam logic [2:0] LD_SRCZ2 = 3'd4;
    localparam logic [2:0] LD_IINC  = 3'd5;
    localparam logic [2:0] LD_ZINC  = 3'd6;

    // Architectural state
    logic [DW-1:0]    patd, patf, srcz1, srcz2;
    logic [23:0]      iinc;
    logic [31:0]      zinc;
    logic [LANES-1:0] icarry, zcarry;

    // Strobe arbitration
    logic win_patf, win_patd, win_srcz1, win_srcz2, win_sh;
    logic any_strobe, multi_strobe;
    logic [2:0] strobe_cnt;

    // Adder lanes
    logic [15:0]       lane_a   [LANES];
    logic [15:0]       lane_b   [LANES];
    logic [15:0]       lane_res [LANES];
    logic [16:0]       lane_sum [LANES];
    logic signed [9:0] lane_isum[LANES];
    logic [7:0]        lane_ilo [LANES];
    logic [LANES-1:0]  cin_vec;
    logic [LANES-1:0]  lane_cout;
    logic [DW-1:0]     result;

    // Next-state values for the strobe/load targets
    logic [DW-1:0] patd_nxt, patf_nxt, srcz1_nxt, srcz2_nxt;

    // Replace the half of a 64-bit register chosen by hi with din.
    function automatic logic [DW-1:0] merge_half(input logic [DW-1:0] cur,
                                                 input logic hi,
                                                 input logic [31:0] din);
        logic [DW-1:0] v;
        v = cur;
        if (hi) v[63:32] = din;
        else    v[31:0]  = din;
        return v;
    endfunction

    // Fixed-priority arbitration of the add strobes; a conflict is any cycle with two or more.
    always_comb begin
        win_patf   = bus.patfadd;
        win_patd   = bus.patdadd  & ~bus.patfadd;
        win_srcz1  = bus.srcz1add & ~bus.patfadd & ~bus.patdadd;
        win_srcz2  = bus.srcz2add & ~bus.patfadd & ~bus.patdadd & ~bus.srcz1add;
        win_sh     = bus.srcshadd & ~bus.patfadd & ~bus.patdadd & ~bus.srcz1add
                                  & ~bus.srcz2add;
        strobe_cnt = {2'b00, bus.patfadd} + {2'b00, bus.patdadd} + {2'b00, bus.srcz1add}
                   + {2'b00, bus.srcz2add} + {2'b00, bus.srcshadd};
        any_strobe   = (strobe_cnt != 3'd0);
        multi_strobe = (strobe_cnt > 3'd1);
    end

    // Carry-in: integer adds consume the carries left by their fraction add.
    always_comb begin
        cin_vec = '0;
        if (win_patd)       cin_vec = icarry;
        else if (win_srcz2) cin_vec = zcarry;
    end

    // Per-lane operand select and add in the selected mode.
    always_comb begin
        result    = '0;
        lane_cout = '0;
        for (int l = 0; l < LANES; l++) begin
            case (bus.daddasel)
                3'b000:  lane_a[l] = bus.srcd[l*16 +: 16];
                3'b100:  lane_a[l] = patd[l*16 +: 16];
                3'b101:  lane_a[l] = patf[l*16 +: 16];
                3'b110:  lane_a[l] = srcz2[l*16 +: 16];
                3'b111:  lane_a[l] = srcz1[l*16 +: 16];
                default: lane_a[l] = 16'h0000;
            endcase

            case (bus.daddbsel)
                3'b001:  lane_b[l] = {{8{bus.shade[7]}}, bus.shade};
                3'b100:  lane_b[l] = {{8{iinc[23]}}, iinc[23:16]};
                3'b101:  lane_b[l] = iinc[15:0];
                3'b110:  lane_b[l] = zinc[31:16];
                3'b111:  lane_b[l] = zinc[15:0];
                default: lane_b[l] = 16'h0000;
            endcase

            // Mode 001 is the fraction add: no carry in, carry out captured.
            lane_sum[l] = {1'b0, lane_a[l]} + {1'b0, lane_b[l]}
                        + {16'b0, (bus.daddmode == 3'b001) ? 1'b0 : cin_vec[l]};
            lane_cout[l] = lane_sum[l][16];

            // Intensity byte: unsigned A plus signed B, range -128..383.
            lane_isum[l] = $signed({2'b00, lane_a[l][7:0]})
                         + $signed({{2{lane_b[l][7]}}, lane_b[l][7:0]})
                         + $signed({9'b0, cin_vec[l]});
            if (SAT_EN && lane_isum[l][9])      lane_ilo[l] = 8'h00;
            else if (SAT_EN && lane_isum[l][8]) lane_ilo[l] = 8'hFF;
            else                                lane_ilo[l] = lane_isum[l][7:0];

            case (bus.daddmode)
                3'b000, 3'b001: lane_res[l] = lane_sum[l][15:0];
                3'b010:         lane_res[l] = {lane_a[l][15:8], lane_ilo[l]};
                default:        lane_res[l] = lane_a[l];
            endcase

            result[l*16 +: 16] = lane_res[l];
        end
    end

    // Next register values: strobe result first, then a GPU load overrides its half.
    always_comb begin
        patd_nxt  = win_patd  ? result : patd;
        patf_nxt  = win_patf  ? result : patf;
        srcz1_nxt = win_srcz1 ? result : srcz1;
        srcz2_nxt = win_srcz2 ? result : srcz2;
        if (bus.reg_ld == LD_PATD)  patd_nxt  = merge_half(patd_nxt,  bus.reg_hi, bus.gpu_din);
        if (bus.reg_ld == LD_PATF)  patf_nxt  = merge_half(patf_nxt,  bus.reg_hi, bus.gpu_din);
        if (bus.reg_ld == LD_SRCZ1) srcz1_nxt = merge_half(srcz1_nxt, bus.reg_hi, bus.gpu_din);
        if (bus.reg_ld == LD_SRCZ2) srcz2_nxt = merge_half(srcz2_nxt, bus.reg_hi, bus.gpu_din);
    end

    // Pattern, Z and increment registers.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            patd  <= '0;
            patf  <= '0;
            srcz1 <= '0;
            srcz2 <= '0;
            iinc  <= '0;
            zinc  <= '0;
        end else begin
            patd  <= patd_nxt;
            patf  <= patf_nxt;
            srcz1 <= srcz1_nxt;
            srcz2 <= srcz2_nxt;
            if (bus.reg_ld == LD_IINC) iinc <= bus.gpu_din[23:0];
            if (bus.reg_ld == LD_ZINC) zinc <= bus.gpu_din;
        end
    end

    // Fraction-to-integer carries: set by a mode-001 fraction add, cleared by the consumer.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            icarry <= '0;
            zcarry <= '0;
        end else begin
            if (win_patf && bus.daddmode == 3'b001) icarry <= lane_cout;
            else if (win_patd)                      icarry <= '0;
            if (win_srcz1 && bus.daddmode == 3'b001) zcarry <= lane_cout;
            else if (win_srcz2)                      zcarry <= '0;
        end
    end

    // Registered result, its valid pulse, and the sticky conflict flag.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            bus.daddq        <= '0;
            bus.daddq_valid  <= 1'b0;
            bus.protocol_err <= 1'b0;
        end else begin
            if (any_strobe || bus.daddq_sel) bus.daddq <= result;
            bus.daddq_valid <= any_strobe;
            if (multi_strobe) bus.protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dadd_datapath.sv
// Directed bench for dadd_datapath: loads, fraction/integer add chains,
// intensity saturation, shading, strobe conflict, reset and load collision.
module tb_dadd_datapath;

    logic sys_clk;
    logic resetl;
    int   n_cmp;
    int   n_err;

    dadd_datapath_if bus();

    dadd_datapath #(.LANES(4), .SAT_EN(1'b1)) dut (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .bus     (bus)
    );

    // Clock
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Advance one edge and settle past it.
    task automatic cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [2:0] sel, input logic hi, input logic [31:0] d);
        bus.reg_ld  = sel;
        bus.reg_hi  = hi;
        bus.gpu_din = d;
        cycle();
        bus.reg_ld  = 3'd0;
    endtask

    // stb = {patfadd, patdadd, srcz1add, srcz2add, srcshadd}
    task automatic do_add(input logic [2:0] asel, input logic [2:0] bsel,
                          input logic [2:0] mode, input logic [4:0] stb);
        bus.daddasel = asel;
        bus.daddbsel = bsel;
        bus.daddmode = mode;
        {bus.patfadd, bus.patdadd, bus.srcz1add, bus.srcz2add, bus.srcshadd} = stb;
        cycle();
        {bus.patfadd, bus.patdadd, bus.srcz1add, bus.srcz2add, bus.srcshadd} = 5'b0;
        bus.reg_ld = 3'd0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        resetl = 1'b0;
        bus.gpu_din = '0; bus.reg_ld = '0; bus.reg_hi = 1'b0;
        bus.daddasel = '0; bus.daddbsel = '0; bus.daddmode = '0;
        bus.daddq_sel = 1'b0;
        bus.patdadd = 1'b0; bus.patfadd = 1'b0; bus.srcz1add = 1'b0;
        bus.srcz2add = 1'b0; bus.srcshadd = 1'b0;
        bus.srcd = '0; bus.shade = '0;
        cycle();
        cycle();
        chk("rst_daddq", bus.daddq, 64'h0);
        chk("rst_valid", {63'b0, bus.daddq_valid}, 64'h0);
        chk("rst_perr", {63'b0, bus.protocol_err}, 64'h0);
        chk("rst_patd", dut.patd, 64'h0);
        resetl = 1'b1;
        cycle();

        // Fraction add on patf produces carries, integer add on patd consumes them.
        load(3'd1, 1'b1, 32'h0010_0020);
        load(3'd1, 1'b0, 32'h0030_0040);
        load(3'd5, 1'b0, 32'h0001_8000);
        load(3'd2, 1'b1, 32'h8000_8000);
        load(3'd2, 1'b0, 32'h8000_8000);
        chk("ld_patd", dut.patd, 64'h0010_0020_0030_0040);
        do_add(3'b101, 3'b101, 3'b001, 5'b10000);
        chk("patf_frac", dut.patf, 64'h0);
        chk("icarry_set", {60'b0, dut.icarry}, 64'hF);
        chk("patf_valid", {63'b0, bus.daddq_valid}, 64'h1);
        do_add(3'b100, 3'b100, 3'b000, 5'b01000);
        chk("patd_int", dut.patd, 64'h0012_0022_0032_0042);
        chk("patd_daddq", bus.daddq, 64'h0012_0022_0032_0042);
        chk("patd_valid", {63'b0, bus.daddq_valid}, 64'h1);
        chk("icarry_clr", {60'b0, dut.icarry}, 64'h0);
        cycle();
        chk("idle_valid", {63'b0, bus.daddq_valid}, 64'h0);
        chk("idle_hold", bus.daddq, 64'h0012_0022_0032_0042);

        // daddq_sel alone captures the pass-through of patf (zero), no valid pulse.
        bus.daddasel = 3'b101; bus.daddbsel = 3'b000; bus.daddmode = 3'b100;
        bus.daddq_sel = 1'b1;
        cycle();
        bus.daddq_sel = 1'b0;
        chk("sel_daddq", bus.daddq, 64'h0);
        chk("sel_valid", {63'b0, bus.daddq_valid}, 64'h0);

        // Intensity saturation high and low.
        load(3'd1, 1'b1, 32'h12F0_12F0);
        load(3'd1, 1'b0, 32'h12F0_12F0);
        load(3'd5, 1'b0, 32'h0020_0000);
        do_add(3'b100, 3'b100, 3'b010, 5'b01000);
        chk("int_sat_hi", dut.patd, 64'h12FF_12FF_12FF_12FF);
        load(3'd1, 1'b1, 32'h1210_1210);
        load(3'd1, 1'b0, 32'h1210_1210);
        load(3'd5, 1'b0, 32'h00E0_0000);
        do_add(3'b100, 3'b100, 3'b010, 5'b01000);
        chk("int_sat_lo", dut.patd, 64'h1200_1200_1200_1200);

        // Z chain: srcz1 fraction overflow carries into srcz2.
        load(3'd3, 1'b1, 32'hFFFF_FFFF);
        load(3'd3, 1'b0, 32'hFFFF_FFFF);
        load(3'd6, 1'b0, 32'h0003_0001);
        do_add(3'b111, 3'b111, 3'b001, 5'b00100);
        chk("srcz1_frac", dut.srcz1, 64'h0);
        chk("zcarry_set", {60'b0, dut.zcarry}, 64'hF);
        load(3'd4, 1'b1, 32'h0100_0100);
        load(3'd4, 1'b0, 32'h0100_0100);
        do_add(3'b110, 3'b110, 3'b000, 5'b00010);
        chk("srcz2_int", dut.srcz2, 64'h0104_0104_0104_0104);
        chk("zcarry_clr", {60'b0, dut.zcarry}, 64'h0);

        // Shade add: result only.
        bus.srcd  = 64'h00FF_0080_0010_0000;
        bus.shade = 8'h10;
        do_add(3'b000, 3'b001, 3'b010, 5'b00001);
        chk("shade_daddq", bus.daddq, 64'h00FF_0090_0020_0010);
        chk("shade_patd", dut.patd, 64'h1200_1200_1200_1200);
        chk("shade_srcz2", dut.srcz2, 64'h0104_0104_0104_0104);
        chk("shade_perr", {63'b0, bus.protocol_err}, 64'h0);

        // Conflict: patdadd beats srcz1add; patd + (-32) per lane.
        do_add(3'b100, 3'b100, 3'b000, 5'b01100);
        chk("conf_patd", dut.patd, 64'h11E0_11E0_11E0_11E0);
        chk("conf_srcz1", dut.srcz1, 64'h0);
        chk("conf_perr", {63'b0, bus.protocol_err}, 64'h1);
        cycle(); cycle(); cycle();
        chk("perr_sticky", {63'b0, bus.protocol_err}, 64'h1);

        // Leave carries pending, then reset mid-sequence.
        load(3'd5, 1'b0, 32'h0001_8000);
        load(3'd2, 1'b1, 32'h8000_8000);
        load(3'd2, 1'b0, 32'h8000_8000);
        do_add(3'b101, 3'b101, 3'b001, 5'b10000);
        chk("pend_icarry", {60'b0, dut.icarry}, 64'hF);
        resetl = 1'b0;
        cycle();
        resetl = 1'b1;
        cycle();
        chk("rst2_perr", {63'b0, bus.protocol_err}, 64'h0);
        chk("rst2_icarry", {60'b0, dut.icarry}, 64'h0);
        chk("rst2_daddq", bus.daddq, 64'h0);

        // Load/strobe collision on patd low half; cin is 0 after reset.
        load(3'd5, 1'b0, 32'h0005_0000);
        load(3'd1, 1'b1, 32'h0001_0002);
        bus.reg_ld  = 3'd1;
        bus.reg_hi  = 1'b0;
        bus.gpu_din = 32'hAAAA_5555;
        do_add(3'b100, 3'b100, 3'b000, 5'b01000);
        chk("coll_daddq", bus.daddq, 64'h0006_0007_0005_0005);
        chk("coll_patd", dut.patd, 64'h0006_0007_AAAA_5555);
        chk("coll_valid", {63'b0, bus.daddq_valid}, 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
